// File: rtl/ucsbece154b_icache_if.sv
// Fetch-side and memory-side signals of the instruction cache.
//
// Handshake semantics (one place, applies to every channel below):
//   * Fetch: ReadEnable_i/ReadAddress_i is a request offered every cycle; it is
//     consumed only in a cycle where Ready_o=1. When Ready_o=0 the requester
//     keeps stalling and may re-present any address; nothing is queued.
//   * Line request: MemReadRequest_o is a single-cycle pulse carrying
//     MemReadAddress_o; memory must accept it unconditionally (no back-pressure).
//   * Fill data: MemDataReady_i qualifies MemDataIn_i for exactly one word per
//     cycle, in offset order; the cache always accepts (no back-pressure).
interface ucsbece154b_icache_if;
    logic        ReadEnable_i;
    logic [31:0] ReadAddress_i;
    logic [31:0] Instruction_o;
    logic        Ready_o;
    logic        Busy_o;
    logic        MemReadRequest_o;
    logic [31:0] MemReadAddress_o;
    logic        MemDataReady_i;
    logic [31:0] MemDataIn_i;
    logic [31:0] HitCount_o;
    logic [31:0] MissCount_o;

    // Cache side.
    modport slave (
        input  ReadEnable_i, ReadAddress_i, MemDataReady_i, MemDataIn_i,
        output Instruction_o, Ready_o, Busy_o, MemReadRequest_o,
               MemReadAddress_o, HitCount_o, MissCount_o
    );

    // Datapath / memory side.
    modport master (
        output ReadEnable_i, ReadAddress_i, MemDataReady_i, MemDataIn_i,
        input  Instruction_o, Ready_o, Busy_o, MemReadRequest_o,
               MemReadAddress_o, HitCount_o, MissCount_o
    );
endinterface

// File: rtl/ucsbece154b_icache.sv
// Direct-mapped read-only instruction cache. Hits are served combinationally
// in IDLE; a miss requests the whole line, collects the words in order,
// installs tag/valid with the last word and returns to IDLE for the replay.
module ucsbece154b_icache #(
    parameter int NUM_SETS    = 8,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    ucsbece154b_icache_if.slave        bus,
    output logic [1:0]                 DebugState_o
);

    localparam int O  = $clog2(BLOCK_WORDS);
    localparam int I  = $clog2(NUM_SETS);
    localparam int OW = (O > 0) ? O : 1;   // offset/counter width, at least one bit
    localparam int TW = 32 - O - I - 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } state_t;

    state_t state, stateNext;

    logic [NUM_SETS-1:0] validQ;
    logic [TW-1:0]       tagQ  [NUM_SETS];
    logic [31:0]         dataQ [NUM_SETS][BLOCK_WORDS];

    logic [OW-1:0] wordCnt;
    logic [31:0]   fillAddr;     // line address of the fill in flight (or the last one)
    logic [31:0]   hitCount;
    logic [31:0]   missCount;

    // Lookup address split.
    logic [OW-1:0] rdOffset;
    logic [I-1:0]  rdIndex;
    logic [TW-1:0] rdTag;
    assign rdOffset = OW'(bus.ReadAddress_i[31:2] & 30'(BLOCK_WORDS - 1));
    assign rdIndex  = bus.ReadAddress_i[O+I+1:O+2];
    assign rdTag    = bus.ReadAddress_i[31:O+I+2];

    // Fill target taken from the latched line address.
    logic [I-1:0]  fillIndex;
    logic [TW-1:0] fillTag;
    assign fillIndex = fillAddr[O+I+1:O+2];
    assign fillTag   = fillAddr[31:O+I+2];

    logic hit;
    logic missEvent;
    logic fillWord;
    logic lastWord;
    assign hit       = bus.ReadEnable_i && validQ[rdIndex] &&
                       (tagQ[rdIndex] == rdTag) && (state == IDLE);
    assign missEvent = (state == IDLE) && bus.ReadEnable_i && !hit;
    assign fillWord  = (state == FILL) && bus.MemDataReady_i;
    assign lastWord  = (wordCnt == OW'(BLOCK_WORDS - 1));

    // Next-state logic: a fill always runs to completion once started.
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (missEvent) stateNext = REQ;
            REQ:     stateNext = FILL;
            FILL:    if (fillWord && lastWord) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Control state: FSM, valid bits, fill address, word counter, statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            validQ    <= '0;
            wordCnt   <= '0;
            fillAddr  <= '0;
            hitCount  <= '0;
            missCount <= '0;
        end else begin
            state <= stateNext;
            if (hit && (hitCount != 32'hFFFF_FFFF)) begin
                hitCount <= hitCount + 32'd1;
            end
            if (missEvent) begin
                fillAddr <= {rdTag, rdIndex, {(O + 2){1'b0}}};
                wordCnt  <= '0;
                if (missCount != 32'hFFFF_FFFF) begin
                    missCount <= missCount + 32'd1;
                end
            end
            if (fillWord) begin
                wordCnt <= wordCnt + 1'b1;
                if (lastWord) begin
                    validQ[fillIndex] <= 1'b1;
                end
            end
        end
    end

    // Tag and data storage: not reset; guarded by the valid bits.
    always_ff @(posedge clk) begin
        if (!reset && fillWord) begin
            dataQ[fillIndex][wordCnt] <= bus.MemDataIn_i;
            if (lastWord) begin
                tagQ[fillIndex] <= fillTag;
            end
        end
    end

    assign bus.Ready_o          = hit;
    assign bus.Instruction_o    = dataQ[rdIndex][rdOffset];
    assign bus.Busy_o           = (state != IDLE);
    assign bus.MemReadRequest_o = (state == REQ);
    assign bus.MemReadAddress_o = fillAddr;
    assign bus.HitCount_o       = hitCount;
    assign bus.MissCount_o      = missCount;
    assign DebugState_o         = state;

endmodule

// File: doc/ucsbece154b_icache.md
# ucsbece154b_icache

Direct-mapped, read-only instruction cache between the fetch stage's PC register and main instruction memory. A hit returns the instruction combinationally in the same cycle. A miss runs a fill state machine that requests a whole line, accepts words from memory in order, installs the line, and then serves the fetch on replay. The datapath holds fetch and decode (StallF/StallD) while `Ready_o` is low.

## Interface
Parameters:
- `NUM_SETS`, 8: number of lines; power of 2, at least 2.
- `BLOCK_WORDS`, 4: 32-bit words per line; power of 2, at least 1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `ReadEnable_i`  in  1  fetch request valid this cycle.
- `ReadAddress_i`  in  32  fetch address (PCF); bits [1:0] ignored.
- `Instruction_o`  out  32  hit data; undefined when `Ready_o`=0.
- `Ready_o`  out  1  fetch satisfied this cycle.
- `Busy_o`  out  1  fill in progress (state is not IDLE).
- `MemReadRequest_o`  out  1  one-cycle line-request pulse.
- `MemReadAddress_o`  out  32  line-aligned fill address; low `log2(BLOCK_WORDS)+2` bits are zero.
- `MemDataReady_i`  in  1  memory word valid.
- `MemDataIn_i`  in  32  memory word; words arrive in order from offset 0 to `BLOCK_WORDS`-1.
- `HitCount_o`  out  32  saturating hit counter.
- `MissCount_o`  out  32  saturating miss counter.

## Operation
- Address split, with O=log2(`BLOCK_WORDS`) and I=log2(`NUM_SETS`):
  - offset = addr[O+1:2]
  - index = addr[O+I+1:O+2]
  - tag = addr[31:O+I+2]
- Storage per set: valid bit, tag, and `BLOCK_WORDS` data words.
- Hit = `ReadEnable_i` & valid[index] & (tag match) & state==IDLE.
- `Ready_o` = hit. `Instruction_o` = data[index][offset], combinational.
- States: IDLE, REQ, FILL.
- IDLE:
  - On a hit, stay in IDLE and increment `HitCount_o`.
  - On `ReadEnable_i` with a miss, latch the tag/index of `ReadAddress_i` into the fill-address register, clear the word counter, increment `MissCount_o`, and go to REQ.
  - With `ReadEnable_i`=0, do nothing.
- REQ: assert `MemReadRequest_o`=1 for exactly this cycle; `MemReadAddress_o` = {latched tag, index, zeros}. Go to FILL.
- FILL:
  - Each cycle with `MemDataReady_i`=1, write `MemDataIn_i` to data[latched index][counter] and increment the counter.
  - On the word with counter = `BLOCK_WORDS`-1, write tag[index] and set valid[index]=1 on the same edge, then go to IDLE.
- The fill is non-abortable. Changes to `ReadAddress_i` or `ReadEnable_i` during REQ/FILL do not affect the fill. After returning to IDLE, whatever address is then presented is looked up normally.
- A fill into an occupied set overwrites it. Valid is not cleared at fill start; the set is unreachable during the fill because `Ready_o`=0 outside IDLE.
- `MemDataReady_i` is ignored in IDLE and REQ.
- Counters saturate at 0xFFFFFFFF.
- `MemReadAddress_o` holds its last value outside REQ.

## Timing
- Reset values:
  - state IDLE, all valid bits 0, word counter 0.
  - `MemReadRequest_o`=0, `Busy_o`=0, `MemReadAddress_o`=0.
  - `HitCount_o`=0, `MissCount_o`=0.
  - `Ready_o`=0 (no line is valid).
  - Tag and data arrays are not reset.
- Hit latency: 0 cycles (combinational).
- Miss timeline, with memory first-word latency L (cycles after the REQ cycle) and back-to-back words:
  - Miss detected at cycle t.
  - REQ at t+1.
  - Words arrive at t+1+L through t+L+`BLOCK_WORDS`.
  - IDLE and hit at t+L+`BLOCK_WORDS`+1.
  - Gaps in `MemDataReady_i` extend FILL cycle-for-cycle.
- `Busy_o` is high from t+1 through the last-word cycle inclusive.
- Reset mid-fill: state goes to IDLE next cycle and all valid bits clear. Later `MemDataReady_i` pulses from the abandoned request are ignored.
- A miss and a counter increment occur on the same edge that leaves IDLE.

## Test plan
- Cold miss (`NUM_SETS`=8, `BLOCK_WORDS`=4, memory L=3): after reset, fetch 0x00010000, memory words 0xA0..0xA3.
  - Required: `MemReadRequest_o` pulses once with `MemReadAddress_o`=0x00010000.
  - Required: `Ready_o`=1 with `Instruction_o`=0xA0 exactly 8 cycles after the miss cycle.
  - Required: `MissCount_o`=1.
- Line hits: fetch 0x00010004, 0x00010008, 0x0001000C on consecutive cycles.
  - Required: `Ready_o`=1 each cycle, data 0xA1/0xA2/0xA3, no memory request, `HitCount_o`=4 (including the replay hit).
- Conflict eviction: fetch 0x00010080 (same index 0, different tag), then 0x00010000 again.
  - Required: two misses, each with a one-cycle request (0x00010080, then 0x00010000).
  - Required: final `MissCount_o`=3 and correct data after each fill.
- Address change mid-fill: switch `ReadAddress_i` to 0x00020040 two cycles into a FILL for 0x00010010.
  - Required: fill completes into index 1 with the 0x00010010 tag.
  - Required: the next cycle in IDLE misses on 0x00020040 and issues a request with `MemReadAddress_o`=0x00020040.
- Reset mid-fill: assert `reset` after 2 of 4 words, then deliver 2 stray `MemDataReady_i` pulses.
  - Required: next cycle `Busy_o`=0 and `MemReadRequest_o`=0, counters 0.
  - Required: stray pulses cause no state change, and a fetch of 0x00010000 misses.
- Memory gaps: insert idle cycles between fill words.
  - Required: FILL lasts exactly 4 `MemDataReady_i` pulses plus the gap cycles.
  - Required: `Ready_o` stays 0 until the cycle after the last word.
